uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receiver: the next generation of the single-format 8N1 receiver used in the UART peripheral. It adds configurable data width, parity, 1/2 stop bits, an input synchroniser, false-start rejection, error flags and a valid/ready output holding register with overrun detection. It sits between the `uart_rx` pad and the UART controller's register/FIFO interface.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `clk`  in  1  clock.
- `rstn`  in  1  reset: synchronous, active-low.
- `rec_en`  in  1  receiver enable.
- `dfv`  in  16  bit period minus one, in `clk` cycles; legal range ≥ 3.
- `par_mode`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1  1 = two stop bits, 0 = one stop bit.
- `rx_data`  out  DATA_W  received word, LSB first on the line.
- `rx_perr`  out  1  parity error attached to `rx_data`.
- `rx_ferr`  out  1  framing error attached to `rx_data`.
- `rx_valid`  out  1  output word valid.
- `rx_ready`  in  1  consumer accepts word.
- `rx_overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `rx_busy`  out  1  FSM not in IDLE.
- `uart_rx`  in  1  asynchronous serial line; idles high.

## Operation
- Synchroniser: 2-flop chain on `uart_rx` gives `rx_s`; both flops reset to 1. All FSM decisions use `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit counter `cnt` (16 bit) runs in every state except IDLE. It increments each cycle; at `cnt == dfv` it wraps to 0 and the bit ends. The mid-bit sample point is `cnt == dfv>>1`.
- IDLE: if `rx_s == 0`, go to START with `cnt = 0`.
- START: at mid-bit, if `rx_s == 1` (false start), return to IDLE; no output and no flags. At bit end, go to DATA with bit index 0.
- DATA: at mid-bit, shift `rx_s` into the MSB of the shift register (right-shift), so the first line bit ends up in bit 0. After `DATA_W` bits, go to PARITY if `par_mode` is 01 or 10, otherwise go to STOP.
- PARITY: at mid-bit, compute the XOR of the data bits and the sampled bit. Parity error is set when that XOR is 1 in even mode, or 0 in odd mode. At bit end, go to STOP.
- STOP: with `stop2 = 1`, the first stop bit runs a full period and the second is sampled at mid-bit. Framing error is set if any sampled stop bit is 0.
  - At the final stop mid-bit sample, the frame commits and the FSM returns to IDLE that same edge. It does not wait for the bit end, so it can resync to a following start bit.
- Commit:
  - If `rx_valid == 0`, or `rx_valid && rx_ready` on the same cycle, load `rx_data`, `rx_perr`, `rx_ferr` and set `rx_valid`.
  - Otherwise the holding register is unchanged, the new frame is discarded and `rx_overrun` pulses.
- Handshake: `rx_valid` clears on the cycle after `rx_valid && rx_ready` unless a commit happens on the same edge. While `rx_valid` is high, `rx_data`, `rx_perr` and `rx_ferr` are stable.
- `par_mode`, `stop2`, `dfv`: sampled live. Software changes them only while `rx_busy == 0`.
- `rec_en = 0`: FSM forced to IDLE, `cnt`, bit index and shift register cleared, any frame in progress aborted silently. The holding register and `rx_valid` are unaffected; a handshake still completes.
- `rstn = 0`: everything cleared.

## Timing
- Reset values: `rx_data = 0`, `rx_perr = 0`, `rx_ferr = 0`, `rx_valid = 0`, `rx_overrun = 0`, `rx_busy = 0`, FSM IDLE.
- Input latency: 2 cycles of synchroniser, plus 1 cycle for IDLE detection.
- `rx_valid` rises on the edge of the final stop-bit mid sample. The frame sits in the holding register about half a bit before the line stop bit ends.
- Bit period is `dfv + 1` cycles.
- Frame length is (1 + DATA_W + P + S) bits, where P is 0 or 1 for parity and S is 1 or 2 for stop bits.
- `rx_overrun` is high for exactly one cycle per dropped frame.
- `rx_busy` is high from the cycle after START entry until the cycle after commit or abort.

## Configuration
- `UART_RX_FRAME_PARITY_EN` defined: PARITY state, `par_mode` decoding and `rx_perr` logic are present, as described above.
- Not defined: the PARITY state is not built and `par_mode` is ignored (treated as 00). `rx_perr` is tied to 0 and frames are always 1 + DATA_W + S bits.

## Test plan
- DATA_W=8, `dfv=15`, none, 1 stop, send 0xA5: `rx_data = 0xA5`, `rx_perr = 0`, `rx_ferr = 0`, `rx_valid` high until `rx_ready` pulse.
- `par_mode=01`, send 0x03 with parity bit 1: `rx_perr = 1`. Repeat with parity bit 0: `rx_perr = 0`. With `par_mode=10`, parity bit 1 gives `rx_perr = 0`.
- `stop2=1`, second stop bit driven 0, data 0x5A: `rx_data = 0x5A`, `rx_ferr = 1`. Next frame 0x11 with valid stop bits: `rx_ferr = 0`.
- Line low for 5 cycles then high (`dfv=15`): FSM returns to IDLE, no `rx_valid`, `rx_busy` back to 0.
- Two back-to-back frames 0x12, 0x34 with `rx_ready` held 0: `rx_data` stays 0x12, `rx_overrun` pulses once.
- Drop `rec_en` mid-frame, re-enable, then send 0x77: only 0x77 is delivered. DATA_W=5 build with 0x15 received as 0x15.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchroniser, start/data/parity/stop FSM, valid/ready holding register.
// Define UART_RX_FRAME_PARITY_EN to build the parity state, par_mode decoding and rx_perr logic.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rec_en,
    input  logic [15:0]       dfv,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              rx_busy,
    input  logic              uart_rx
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              stop_idx_q, stop_idx_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hold_ferr_q, hold_ferr_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic rx_s;
    logic mid;
    logic bit_end;
    logic commit;
    logic par_en;

`ifdef UART_RX_FRAME_PARITY_EN
    logic perr_q, perr_d;
    logic hold_perr_q, hold_perr_d;
    logic par_odd;

    assign par_en  = (par_mode == 2'b01) || (par_mode == 2'b10);
    assign par_odd = (par_mode == 2'b10);
    assign rx_perr = hold_perr_q;
`else
    logic unused_par_mode;

    assign par_en          = 1'b0;
    assign unused_par_mode = ^par_mode;
    assign rx_perr         = 1'b0;
`endif

    assign rx_s       = sync2_q;
    assign mid        = (cnt_q == (dfv >> 1));
    assign bit_end    = (cnt_q == dfv);
    assign rx_data    = data_q;
    assign rx_ferr    = hold_ferr_q;
    assign rx_valid   = valid_q;
    assign rx_overrun = overrun_q;
    assign rx_busy    = (state_q != StIdle);

    always_comb begin
        sync1_d     = uart_rx;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = bit_end ? 16'd0 : cnt_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_idx_d  = stop_idx_q;
        ferr_d      = ferr_q;
        data_d      = data_q;
        hold_ferr_d = hold_ferr_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_FRAME_PARITY_EN
        perr_d      = perr_q;
        hold_perr_d = hold_perr_q;
`endif

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    state_d    = StStart;
                    bit_idx_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    ferr_d     = 1'b0;
`ifdef UART_RX_FRAME_PARITY_EN
                    perr_d     = 1'b0;
`endif
                end
            end
            StStart: begin
                if (mid && rx_s) begin
                    // Glitch or noise: abandon without any output.
                    state_d = StIdle;
                    cnt_d   = 16'd0;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 4'd0;
                end
            end
            StData: begin
                if (mid) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == 4'(DATA_W - 1)) begin
                        state_d    = par_en ? StParity : StStop;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_FRAME_PARITY_EN
            StParity: begin
                if (mid) begin
                    perr_d = (^shift_q) ^ rx_s ^ par_odd;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (mid) begin
                    ferr_d = ferr_q | ~rx_s;
                    // Commit at the final stop mid-point so a following start bit is not missed.
                    if (!(stop2 && !stop_idx_q)) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                        cnt_d   = 16'd0;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase

        if (!rec_en) begin
            state_d    = StIdle;
            cnt_d      = 16'd0;
            bit_idx_d  = 4'd0;
            shift_d    = '0;
            stop_idx_d = 1'b0;
            ferr_d     = 1'b0;
            commit     = 1'b0;
`ifdef UART_RX_FRAME_PARITY_EN
            perr_d     = 1'b0;
`endif
        end

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d      = shift_q;
                hold_ferr_d = ferr_d;
                valid_d     = 1'b1;
`ifdef UART_RX_FRAME_PARITY_EN
                hold_perr_d = perr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 4'd0;
            shift_q     <= '0;
            stop_idx_q  <= 1'b0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            hold_ferr_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            stop_idx_q  <= stop_idx_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            hold_ferr_q <= hold_ferr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_FRAME_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perr_q      <= 1'b0;
            hold_perr_q <= 1'b0;
        end else begin
            perr_q      <= perr_d;
            hold_perr_q <= hold_perr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8-bit and 5-bit instances, expected frames via a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rec_en = 1'b0;
    logic [15:0] dfv = 16'd15;
    logic [1:0]  par_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        rx_ready = 1'b0;
    logic        rx_ready5 = 1'b0;
    logic        line8 = 1'b1;
    logic        line5 = 1'b1;

    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rx_overrun, rx_busy;
    logic [4:0]  rx_data5;
    logic        rx_perr5, rx_ferr5, rx_valid5, rx_overrun5, rx_busy5;

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_W(8)) u_dut (
        .clk(clk), .rstn(rstn), .rec_en(rec_en), .dfv(dfv), .par_mode(par_mode),
        .stop2(stop2), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .rx_busy(rx_busy), .uart_rx(line8)
    );

    uart_rx_frame #(.DATA_W(5)) u_dut5 (
        .clk(clk), .rstn(rstn), .rec_en(rec_en), .dfv(dfv), .par_mode(par_mode),
        .stop2(stop2), .rx_data(rx_data5), .rx_perr(rx_perr5), .rx_ferr(rx_ferr5),
        .rx_valid(rx_valid5), .rx_ready(rx_ready5), .rx_overrun(rx_overrun5),
        .rx_busy(rx_busy5), .uart_rx(line5)
    );

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb8[$];
    exp_t sb5[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_cnt = 0;

    always @(negedge clk) if (rx_overrun) ovr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; a 0 stop bit is cut short so the line is back high before
    // the receiver could mistake it for a real start bit.
    task automatic send(input bit sel5, input int nbits, input logic [8:0] data,
                        input bit has_par, input logic pbit, input int nstop,
                        input logic [1:0] stops, input bit push, input logic eperr,
                        input logic eferr, input int abort_at);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (has_par) bits.push_back(pbit);
        for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
        if (push) begin
            e.data = data;
            e.perr = eperr;
            e.ferr = eferr;
            if (sel5) sb5.push_back(e); else sb8.push_back(e);
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (i == abort_at) rec_en = 1'b0;
            if (sel5) line5 = bits[i]; else line8 = bits[i];
            if (i > nbits + (has_par ? 1 : 0) && bits[i] == 1'b0) idle(BIT / 2 + 4);
            else idle(BIT);
        end
        if (sel5) line5 = 1'b1; else line8 = 1'b1;
    endtask

    task automatic expect_frame(input bit sel5, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while ((sel5 ? rx_valid5 : rx_valid) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(sel5 ? rx_valid5 : rx_valid), 32'd1);
        chk({tag, "_sbsize"}, 32'(sel5 ? sb5.size() : sb8.size()), 32'd1);
        if ((sel5 ? sb5.size() : sb8.size()) != 0) begin
            e = sel5 ? sb5.pop_front() : sb8.pop_front();
            chk({tag, "_data"}, sel5 ? 32'(rx_data5) : 32'(rx_data), 32'(e.data));
            chk({tag, "_perr"}, 32'(sel5 ? rx_perr5 : rx_perr), 32'(e.perr));
            chk({tag, "_ferr"}, 32'(sel5 ? rx_ferr5 : rx_ferr), 32'(e.ferr));
        end
    endtask

    task automatic ack(input bit sel5, input string tag);
        if (sel5) rx_ready5 = 1'b1; else rx_ready = 1'b1;
        @(negedge clk);
        if (sel5) rx_ready5 = 1'b0; else rx_ready = 1'b0;
        chk({tag, "_cleared"}, 32'(sel5 ? rx_valid5 : rx_valid), 32'd0);
    endtask

    initial begin
        int ovr0;
        idle(3);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_perr", 32'(rx_perr), 32'd0);
        chk("rst_ferr", 32'(rx_ferr), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_overrun", 32'(rx_overrun), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        rstn = 1'b1;
        rec_en = 1'b1;
        idle(20);

        // Basic 8N1 frame, held until the consumer accepts it.
        send(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "a5");
        idle(10);
        chk("a5_hold_valid", 32'(rx_valid), 32'd1);
        chk("a5_hold_data", 32'(rx_data), 32'h0A5);
        ack(1'b0, "a5");
        idle(BIT);

`ifdef UART_RX_FRAME_PARITY_EN
        par_mode = 2'b01;
        send(1'b0, 8, 9'h003, 1'b1, 1'b1, 1, 2'b11, 1'b1, 1'b1, 1'b0, -1);
        expect_frame(1'b0, "even_bad");
        ack(1'b0, "even_bad");
        idle(BIT);
        send(1'b0, 8, 9'h003, 1'b1, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "even_good");
        ack(1'b0, "even_good");
        idle(BIT);
        par_mode = 2'b10;
        send(1'b0, 8, 9'h003, 1'b1, 1'b1, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "odd_good");
        ack(1'b0, "odd_good");
        idle(BIT);
        par_mode = 2'b00;
`else
        // Without the parity build, par_mode must be ignored entirely.
        par_mode = 2'b01;
        send(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "nopar");
        ack(1'b0, "nopar");
        idle(BIT);
        par_mode = 2'b00;
`endif

        stop2 = 1'b1;
        send(1'b0, 8, 9'h05A, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0, 1'b1, -1);
        expect_frame(1'b0, "ferr");
        ack(1'b0, "ferr");
        idle(3 * BIT);
        chk("ferr_busy_idle", 32'(rx_busy), 32'd0);
        send(1'b0, 8, 9'h011, 1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "stop2_ok");
        ack(1'b0, "stop2_ok");
        stop2 = 1'b0;
        idle(BIT);

        // False start: 5 low cycles.
        line8 = 1'b0;
        idle(4);
        chk("fs_busy_high", 32'(rx_busy), 32'd1);
        idle(1);
        line8 = 1'b1;
        idle(40);
        chk("fs_valid", 32'(rx_valid), 32'd0);
        chk("fs_busy_low", 32'(rx_busy), 32'd0);

        // Back-to-back frames with no consumer: second frame dropped.
        ovr0 = ovr_cnt;
        send(1'b0, 8, 9'h012, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        send(1'b0, 8, 9'h034, 1'b0, 1'b0, 1, 2'b11, 1'b0, 1'b0, 1'b0, -1);
        idle(2);
        chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        expect_frame(1'b0, "ovr_keep");
        ack(1'b0, "ovr_keep");
        idle(3 * BIT);
        chk("ovr_no_second", 32'(rx_valid), 32'd0);

        // Abort mid-frame by dropping rec_en.
        send(1'b0, 8, 9'h0C3, 1'b0, 1'b0, 1, 2'b11, 1'b0, 1'b0, 1'b0, 4);
        chk("abort_busy", 32'(rx_busy), 32'd0);
        chk("abort_valid", 32'(rx_valid), 32'd0);
        rec_en = 1'b1;
        idle(10);
        send(1'b0, 8, 9'h077, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b0, "after_abort");
        ack(1'b0, "after_abort");
        chk("sb8_empty", 32'(sb8.size()), 32'd0);

        // Narrow instance.
        send(1'b1, 5, 9'h015, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0, 1'b0, -1);
        expect_frame(1'b1, "w5");
        ack(1'b1, "w5");
        chk("w5_no_leak", 32'(rx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
